// File: rtl/pc_down_decoder.sv
// PC downstream word decoder: splits a 32-bit word stream into config register
// writes, nops, and two-fragment 40-bit BD packets delivered over a valid/ack port.
module pc_down_decoder #(
   parameter int NOPcode = 64,
   parameter int BDcode  = 65,
   parameter int NConf   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pc_in_v,
   input  logic [31:0]           pc_in_d,
   output logic                  pc_in_a,
   output logic                  bd_v,
   output logic [39:0]           bd_d,
   input  logic                  bd_a,
   output logic [NConf*24-1:0]   conf_q,
   output logic                  conf_wr,
   output logic [7:0]            conf_wr_addr,
   output logic [7:0]            err_count
);

   localparam logic [7:0] NOP_C   = 8'(NOPcode);
   localparam logic [7:0] BD_C    = 8'(BDcode);
   localparam logic [8:0] NCONF_L = 9'(NConf);

   typedef enum logic [1:0] {S_LO, S_HI, S_SEND} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [39:0] r_bd_d;
   logic [23:0] r_conf [NConf];
   logic        r_conf_wr;
   logic [7:0]  r_conf_wr_addr;
   logic [7:0]  r_err_count;

   logic [7:0]  w_code;
   logic [23:0] w_payload;
   logic        w_xfer;
   logic        w_is_nop;
   logic        w_is_bd;
   logic        w_is_reg;
   logic        w_is_err;
   logic        w_bd_lo;
   logic        w_bd_hi;

   assign w_code    = pc_in_d[31:24];
   assign w_payload = pc_in_d[23:0];

   // Gating with reset_n keeps the ack low during reset even though state is already S_LO.
   assign pc_in_a = pc_in_v & reset_n & (r_state != S_SEND);
   assign w_xfer  = pc_in_v & pc_in_a;

   // NOP wins over BD, and both win over register decode, if parameters overlap.
   assign w_is_nop = (w_code == NOP_C);
   assign w_is_bd  = !w_is_nop && (w_code == BD_C);
   assign w_is_reg = !w_is_nop && !w_is_bd && ({1'b0, w_code} < NCONF_L);
   assign w_is_err = !w_is_nop && !w_is_bd && !w_is_reg;

   always_comb begin
      w_state_nxt = r_state;
      w_bd_lo     = 1'b0;
      w_bd_hi     = 1'b0;
      case (r_state)
         S_LO: begin
            if (w_xfer && w_is_bd) begin
               w_bd_lo     = 1'b1;
               w_state_nxt = S_HI;
            end
         end
         S_HI: begin
            if (w_xfer && w_is_bd) begin
               w_bd_hi     = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (bd_a) w_state_nxt = S_LO;
         end
         default: w_state_nxt = S_LO;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_LO;
         r_bd_d  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_bd_lo) r_bd_d[23:0]  <= w_payload;
         if (w_bd_hi) r_bd_d[39:24] <= w_payload[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NConf; i++) r_conf[i] <= '0;
         r_conf_wr      <= 1'b0;
         r_conf_wr_addr <= '0;
      end else begin
         r_conf_wr <= w_xfer && w_is_reg;
         if (w_xfer && w_is_reg) begin
            r_conf_wr_addr <= w_code;
            for (int i = 0; i < NConf; i++) begin
               if (w_code == 8'(i)) r_conf[i] <= w_payload;
            end
         end
      end
   end

   // Error counter saturates rather than wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_count <= '0;
      end else if (w_xfer && w_is_err && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   for (genvar g = 0; g < NConf; g++) begin : g_conf
      assign conf_q[g*24 +: 24] = r_conf[g];
   end

   assign bd_v         = (r_state == S_SEND);
   assign bd_d         = r_bd_d;
   assign conf_wr      = r_conf_wr;
   assign conf_wr_addr = r_conf_wr_addr;
   assign err_count    = r_err_count;

endmodule
